uart_baud_gen: RTL and testbench



---
 rtl/uart_baud_gen_if.sv | 35 +++
 rtl/uart_baud_gen.sv | 140 ++++++++++++++
 tb/tb_uart_baud_gen.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_gen_if.sv
// Control and tick bundle between the baud generator and its UART consumers.
// Optional baud_clk square-wave line present when BAUD_CLK_OUT_EN is defined.
interface uart_baud_gen_if #(
    parameter int ACC_W = 24
);
    logic             enable;
    logic [2:0]       baud_sel;
    logic [ACC_W-1:0] inc_custom;
    logic             os_tick;
    logic             bit_tick;
    logic             mid_tick;
`ifdef BAUD_CLK_OUT_EN
    logic             baud_clk;

    modport master (
        output enable, baud_sel, inc_custom,
        input  os_tick, bit_tick, mid_tick, baud_clk
    );

    modport slave (
        input  enable, baud_sel, inc_custom,
        output os_tick, bit_tick, mid_tick, baud_clk
    );
`else
    modport master (
        output enable, baud_sel, inc_custom,
        input  os_tick, bit_tick, mid_tick
    );

    modport slave (
        input  enable, baud_sel, inc_custom,
        output os_tick, bit_tick, mid_tick
    );
`endif
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional phase-accumulator baud generator: oversample, bit and mid-bit enables.
// Define BAUD_CLK_OUT_EN to add the legacy baud_clk square-wave output.
module uart_baud_gen #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_W      = 24
) (
    input  logic         clock,
    input  logic         reset,
    uart_baud_gen_if.slave bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);

    function automatic logic [ACC_W-1:0] calc_inc(input longint unsigned baud);
        longint unsigned num;
        num = baud * 64'(OVERSAMPLE) * (64'd1 << ACC_W) + 64'(CLK_HZ / 2);
        return ACC_W'(num / 64'(CLK_HZ));
    endfunction

    localparam logic [ACC_W-1:0] INC_2400   = calc_inc(64'd2400);
    localparam logic [ACC_W-1:0] INC_4800   = calc_inc(64'd4800);
    localparam logic [ACC_W-1:0] INC_9600   = calc_inc(64'd9600);
    localparam logic [ACC_W-1:0] INC_19200  = calc_inc(64'd19200);
    localparam logic [ACC_W-1:0] INC_38400  = calc_inc(64'd38400);
    localparam logic [ACC_W-1:0] INC_57600  = calc_inc(64'd57600);
    localparam logic [ACC_W-1:0] INC_115200 = calc_inc(64'd115200);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);

    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4 || OVERSAMPLE > 32) begin : g_bad_os
        $error("uart_baud_gen: OVERSAMPLE must be even and within 4..32");
    end
    if (64'(115200) * 64'(OVERSAMPLE) >= 64'(CLK_HZ)) begin : g_bad_clk
        $error("uart_baud_gen: CLK_HZ too low for 115200 baud");
    end
    if (ACC_W < 16 || ACC_W > 32) begin : g_bad_acc
        $error("uart_baud_gen: ACC_W must be within 16..32");
    end

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic             os_q, os_d;
    logic             bit_q, bit_d;
    logic             mid_q, mid_d;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             resync;
`ifdef BAUD_CLK_OUT_EN
    logic             bclk_q, bclk_d;
`endif

    always_comb begin
        inc = '0;
        case (sel_q)
            3'd0:    inc = INC_2400;
            3'd1:    inc = INC_4800;
            3'd2:    inc = INC_9600;
            3'd3:    inc = INC_19200;
            3'd4:    inc = INC_38400;
            3'd5:    inc = INC_57600;
            3'd6:    inc = INC_115200;
            default: inc = bus.inc_custom;
        endcase
    end

    assign sum    = {1'b0, acc_q} + {1'b0, inc};
    assign carry  = sum[ACC_W];
    // A rate change restarts the bit so no truncated bit is ever produced.
    assign resync = bus.enable && (bus.baud_sel != sel_q);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        sel_d = bus.baud_sel;
        os_d  = 1'b0;
        bit_d = 1'b0;
        mid_d = 1'b0;
`ifdef BAUD_CLK_OUT_EN
        bclk_d = bclk_q;
`endif
        if (!bus.enable || resync) begin
            acc_d = '0;
            cnt_d = '0;
`ifdef BAUD_CLK_OUT_EN
            bclk_d = 1'b0;
`endif
        end else begin
            acc_d = sum[ACC_W-1:0];
            if (carry) begin
                os_d  = 1'b1;
                mid_d = (cnt_q == CNT_MID);
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    bit_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`ifdef BAUD_CLK_OUT_EN
                if (bit_d || mid_d) begin
                    bclk_d = ~bclk_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
            sel_q <= '0;
            os_q  <= 1'b0;
            bit_q <= 1'b0;
            mid_q <= 1'b0;
`ifdef BAUD_CLK_OUT_EN
            bclk_q <= 1'b0;
`endif
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            os_q  <= os_d;
            bit_q <= bit_d;
            mid_q <= mid_d;
`ifdef BAUD_CLK_OUT_EN
            bclk_q <= bclk_d;
`endif
        end
    end

    assign bus.os_tick  = os_q;
    assign bus.bit_tick = bit_q;
    assign bus.mid_tick = mid_q;
`ifdef BAUD_CLK_OUT_EN
    assign bus.baud_clk = bclk_q;
`endif
endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: vector table, corner sequences and a randomized run
// checked every cycle against a cumulative-phase reference model.
module tb_uart_baud_gen;
    localparam int W   = 24;
    localparam int OS  = 16;
    localparam int CLK = 50_000_000;

    logic clock;
    logic reset;

    uart_baud_gen_if #(.ACC_W(W)) bus ();

    uart_baud_gen #(
        .CLK_HZ    (CLK),
        .OVERSAMPLE(OS),
        .ACC_W     (W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: total phase since the last clear, never wrapped.
    longint unsigned ph;
    logic [2:0]      msel;
    logic            e_os, e_bit, e_mid, e_bclk;

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] inc;
        int           f_os;
        int           f_mid;
        int           f_bit;
    } vec_t;

    vec_t vecs[5];

    function automatic longint unsigned preset_inc(input logic [2:0] sel);
        longint unsigned baud;
        case (sel)
            3'd0:    baud = 64'd2400;
            3'd1:    baud = 64'd4800;
            3'd2:    baud = 64'd9600;
            3'd3:    baud = 64'd19200;
            3'd4:    baud = 64'd38400;
            3'd5:    baud = 64'd57600;
            default: baud = 64'd115200;
        endcase
        return (baud * 64'(OS) * (64'd1 << W) + 64'(CLK / 2)) / 64'(CLK);
    endfunction

    function automatic longint unsigned ceil_div(input longint unsigned a,
                                                 input longint unsigned b);
        return (a + b - 64'd1) / b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    task automatic step();
        longint unsigned c0, c1, inc;
        @(posedge clock);
        if (reset) begin
            ph = 0; msel = 3'd0;
            e_os = 1'b0; e_bit = 1'b0; e_mid = 1'b0; e_bclk = 1'b0;
        end else if (!bus.enable || bus.baud_sel != msel) begin
            ph = 0; msel = bus.baud_sel;
            e_os = 1'b0; e_bit = 1'b0; e_mid = 1'b0; e_bclk = 1'b0;
        end else begin
            inc = (msel == 3'd7) ? 64'(bus.inc_custom) : preset_inc(msel);
            c0 = ph >> W;
            ph = ph + inc;
            c1 = ph >> W;
            e_os  = (c1 != c0);
            e_bit = e_os && ((c1 % 64'(OS)) == 64'd0);
            e_mid = e_os && ((c1 % 64'(OS)) == 64'(OS / 2));
            if (e_bit || e_mid) e_bclk = ~e_bclk;
        end
        @(negedge clock);
        cyc++;
        chk("ticks", 64'({bus.os_tick, bus.bit_tick, bus.mid_tick}),
            64'({e_os, e_bit, e_mid}));
`ifdef BAUD_CLK_OUT_EN
        chk("baud_clk", 64'(bus.baud_clk), 64'(e_bclk));
`endif
    endtask

    task automatic restart(input logic [2:0] sel, input logic [W-1:0] inc);
        reset = 1'b1;
        bus.enable = 1'b0;
        step();
        reset = 1'b0;
        bus.baud_sel = sel;
        bus.inc_custom = inc;
        step();
        bus.enable = 1'b1;
    endtask

    function automatic int any_tick();
        return (bus.os_tick || bus.bit_tick || bus.mid_tick) ? 1 : 0;
    endfunction

    initial begin
        int fo, fm, fb, nb, last, prev, gmin, gmax, cnt, nos, n;
        vecs[0] = '{3'd7, W'(1 << 20), 16, 128, 256};
        vecs[1] = '{3'd7, W'(1 << 22), 4, 32, 64};
        vecs[2] = '{3'd7, W'(3 << 20), 6, 43, 86};
        vecs[3] = '{3'd6, W'(0), 28, 218, 435};
        vecs[4] = '{3'd2, W'(0), 326, 2605, 5209};

        reset = 1'b1;
        bus.enable = 1'b0;
        bus.baud_sel = 3'd0;
        bus.inc_custom = '0;
        step();
        step();
        chk("reset_state", 64'({bus.os_tick, bus.bit_tick, bus.mid_tick}), 64'd0);

        for (int i = 0; i < 5; i++) begin
            restart(vecs[i].sel, vecs[i].inc);
            fo = 0; fm = 0; fb = 0;
            for (int k = 1; k <= 20000 && fb == 0; k++) begin
                step();
                if (bus.os_tick && fo == 0) fo = k;
                if (bus.mid_tick && fm == 0) fm = k;
                if (bus.bit_tick && fb == 0) fb = k;
            end
            chk($sformatf("vec%0d_first_os", i), 64'(fo), 64'(vecs[i].f_os));
            chk($sformatf("vec%0d_first_mid", i), 64'(fm), 64'(vecs[i].f_mid));
            chk($sformatf("vec%0d_first_bit", i), 64'(fb), 64'(vecs[i].f_bit));
        end

        // 9600 baud over six bits: span and oversample jitter.
        restart(3'd2, '0);
        nb = 0; last = 0; prev = 0; gmin = 1000000; gmax = 0;
        for (int k = 1; k <= 40000 && nb < 6; k++) begin
            step();
            if (bus.os_tick) begin
                if (prev != 0) begin
                    if (k - prev < gmin) gmin = k - prev;
                    if (k - prev > gmax) gmax = k - prev;
                end
                prev = k;
            end
            if (bus.bit_tick) begin
                nb++;
                last = k;
            end
        end
        chk("bits9600", 64'(nb), 64'd6);
        chk("span9600", 64'(last),
            ceil_div(64'(6 * OS) * (64'd1 << W), preset_inc(3'd2)));
        chk("span9600_ideal", 64'((last >= 31249 && last <= 31251) ? 1 : 0), 64'd1);
        chk("gap_min", 64'(gmin), 64'd325);
        chk("gap_max", 64'(gmax), 64'd326);

        // Rate change mid-bit.
        restart(3'd2, '0);
        repeat (3000) step();
        bus.baud_sel = 3'd6;
        step();
        chk("resync_quiet", 64'(any_tick()), 64'd0);
        n = 0; nos = 0;
        for (int k = 1; k <= 2000 && n == 0; k++) begin
            step();
            if (bus.os_tick) nos++;
            if (bus.bit_tick) n = k;
        end
        chk("resync_bit_at", 64'(n), 64'd435);
        chk("resync_os_cnt", 64'(nos), 64'd16);

        // Enable dropped for 10 cycles mid-bit.
        restart(3'd7, W'(1 << 20));
        repeat (100) step();
        bus.enable = 1'b0;
        cnt = 0;
        repeat (10) begin
            step();
            cnt += any_tick();
        end
        chk("disabled_ticks", 64'(cnt), 64'd0);
        bus.enable = 1'b1;
        fo = 0; fm = 0;
        for (int k = 1; k <= 1000 && fm == 0; k++) begin
            step();
            if (bus.os_tick && fo == 0) fo = k;
            if (bus.mid_tick) fm = k;
        end
        chk("reenable_os", 64'(fo), 64'd16);
        chk("reenable_mid", 64'(fm), 64'd128);

        // Reset lands on the edge that would carry the mid tick.
        restart(3'd7, W'(1 << 20));
        repeat (127) step();
        reset = 1'b1;
        step();
        chk("reset_mid", 64'({bus.os_tick, bus.bit_tick, bus.mid_tick}), 64'd0);
        cnt = 0;
        repeat (20) begin
            step();
            cnt += any_tick();
        end
        chk("reset_hold", 64'(cnt), 64'd0);
        reset = 1'b0;
        repeat (300) step();

        // Degenerate custom increments.
        restart(3'd7, '0);
        cnt = 0;
        repeat (300) begin
            step();
            cnt += any_tick();
        end
        chk("zero_inc", 64'(cnt), 64'd0);
        restart(3'd7, '1);
        cnt = 0;
        repeat (200) begin
            step();
            if (bus.os_tick) cnt++;
        end
        chk("ones_os", 64'(cnt), 64'd199);

`ifdef BAUD_CLK_OUT_EN
        begin
            int r1, f1, r2;
            logic pv;
            restart(3'd7, W'(1 << 20));
            r1 = 0; f1 = 0; r2 = 0; pv = 1'b0;
            for (int k = 1; k <= 500 && r2 == 0; k++) begin
                step();
                if (bus.baud_clk && !pv) begin
                    if (r1 == 0) r1 = k;
                    else r2 = k;
                end
                if (!bus.baud_clk && pv && f1 == 0) f1 = k;
                pv = bus.baud_clk;
            end
            chk("bclk_rise", 64'(r1), 64'd128);
            chk("bclk_fall", 64'(f1), 64'd256);
            chk("bclk_rise2", 64'(r2), 64'd384);
        end
`endif

        // Randomized rate, increment and enable activity.
        restart(3'd7, W'(1 << 20));
        for (int k = 0; k < 15000; k++) begin
            if ($urandom_range(0, 199) == 0)
                bus.baud_sel = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0)
                bus.enable = ~bus.enable;
            if (!bus.enable && $urandom_range(0, 19) == 0)
                bus.enable = 1'b1;
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 5))
                    0:       bus.inc_custom = '0;
                    1:       bus.inc_custom = '1;
                    default: bus.inc_custom = W'($urandom_range(1 << 16, 1 << 22));
                endcase
            end
            if ($urandom_range(0, 4999) == 0) reset = 1'b1;
            else reset = 1'b0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
